ysyx_lsu: RTL and testbench

//  Load/store unit directly downstream of the EXU reservation station and store queue.

---
 rtl/ysyx_lsu_pkg.sv | 33 +++
 rtl/ysyx_lsu_if.sv | 24 ++
 rtl/ysyx_lsu_fmt.sv | 25 ++
 rtl/ysyx_lsu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_lsu.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings,
// byte-enable and misalignment helpers. XLEN is the data/address width.
package ysyx_lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RSP   = 2'd2,
        DRAIN = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic [3:0] lsu_wstrb(input logic [2:0] op, input logic [1:0] addr);
        case (op[1:0])
            2'b00:   return 4'b0001 << addr;
            2'b01:   return 4'b0011 << addr;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] addr);
        return ((op[1:0] == 2'b01) && addr[0]) || ((op[1:0] == 2'b10) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_lsu_if.sv
// Single-outstanding memory bus between the LSU (master) and memory (slave).
interface ysyx_lsu_if;
    // A request transfers on a rising edge where mem_req_valid && mem_req_ready; the
    // master holds valid and every request field stable until then. Responses carry no
    // ready: mem_rsp_valid is a one-cycle pulse that the master always accepts.
    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic                            mem_req_we;
    logic [ysyx_lsu_pkg::XLEN-1:0]   mem_req_addr;
    logic [ysyx_lsu_pkg::XLEN-1:0]   mem_req_wdata;
    logic [3:0]                      mem_req_wstrb;
    logic                            mem_rsp_valid;
    logic [ysyx_lsu_pkg::XLEN-1:0]   mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/ysyx_lsu_fmt.sv
// Combinational load formatter: picks the byte/half lane from the raw word and
// sign- or zero-extends it according to funct3.
module ysyx_lsu_fmt
    import ysyx_lsu_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      lane,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[{lane, 3'b000} +: 8];
        half_v = lane[1] ? raw[16 +: 16] : raw[0 +: 16];
        case (op)
            LSU_B:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LSU_H:   data = {{(XLEN-16){half_v[15]}}, half_v};
            LSU_BU:  data = {{(XLEN-8){1'b0}}, byte_v};
            LSU_HU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one access at a time over a single-outstanding bus, flush/drain of
// squashed loads, re-issue suppression. Optional YSYX_LSU_MISALIGN_EN rejects misaligned H/W.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_pipeline,
    input  logic            exu_ren,
    input  logic            exu_wen,
    input  logic            exu_avalid,
    input  logic [4:0]      exu_alu_op,
    input  logic [XLEN-1:0] exu_rwaddr,
    input  logic [XLEN-1:0] exu_wdata,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_exu_rvalid,
    output logic            lsu_exu_wready,
    output logic            lsu_misalign,
    output lsu_state_e      dbg_state,
    ysyx_lsu_if.master      mem
);
    lsu_state_e      state_q, state_d;
    logic [2:0]      op_q, op_d, sup_op_q, sup_op_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sup_addr_q, sup_addr_d;
    logic            we_q, we_d, rvalid_q, rvalid_d, wready_q, wready_d, sup_valid_q, sup_valid_d;
    logic [XLEN-1:0] fmt_data;
    logic [2:0]      op_in;
    logic            suppressed, take_load, take_store;
`ifdef YSYX_LSU_MISALIGN_EN
    logic            misalign_q, misalign_d;
`endif
    logic            unused_op_hi;

    assign unused_op_hi = ^exu_alu_op[4:3];
    assign op_in        = exu_alu_op[2:0];

    ysyx_lsu_fmt u_fmt (
        .raw  (mem.mem_rsp_data),
        .lane (addr_q[1:0]),
        .op   (op_q),
        .data (fmt_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        wready_d    = 1'b0;
        sup_valid_d = sup_valid_q;
        sup_addr_d  = sup_addr_q;
        sup_op_d    = sup_op_q;
`ifdef YSYX_LSU_MISALIGN_EN
        misalign_d  = 1'b0;
`endif
        // EXU holds exu_ren until writeback; a just-completed load must not re-issue
        suppressed = sup_valid_q && (exu_rwaddr == sup_addr_q) && (op_in == sup_op_q);
        take_load  = exu_avalid && exu_ren && !suppressed && !flush_pipeline;
        take_store = exu_avalid && exu_wen && !take_load;
        if (sup_valid_q && (!exu_ren || flush_pipeline ||
                            (exu_rwaddr != sup_addr_q) || (op_in != sup_op_q))) begin
            sup_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (take_load || take_store) begin
                    op_d    = op_in;
                    addr_d  = exu_rwaddr;
                    wdata_d = exu_wdata;
                    we_d    = take_store;
`ifdef YSYX_LSU_MISALIGN_EN
                    if (lsu_misaligned(op_in, exu_rwaddr[1:0])) misalign_d = 1'b1;
                    else                                         state_d    = REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (flush_pipeline && !we_q) state_d = IDLE;
                else if (mem.mem_req_ready)  state_d = RSP;
            end
            RSP: begin
                if (mem.mem_rsp_valid) begin
                    state_d = IDLE;
                    if (we_q) begin
                        wready_d = 1'b1;
                    end else if (!flush_pipeline) begin
                        rvalid_d    = 1'b1;
                        rdata_d     = fmt_data;
                        sup_valid_d = 1'b1;
                        sup_addr_d  = addr_q;
                        sup_op_d    = op_q;
                    end
                end else if (flush_pipeline && !we_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem.mem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            wready_q    <= 1'b0;
            sup_valid_q <= 1'b0;
            sup_addr_q  <= '0;
            sup_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            wready_q    <= wready_d;
            sup_valid_q <= sup_valid_d;
            sup_addr_q  <= sup_addr_d;
            sup_op_q    <= sup_op_d;
        end
    end

`ifdef YSYX_LSU_MISALIGN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign lsu_misalign = misalign_q;
`else
    assign lsu_misalign = 1'b0;
`endif

    assign lsu_rdata         = rdata_q;
    assign lsu_exu_rvalid    = rvalid_q;
    assign lsu_exu_wready    = wready_q;
    assign dbg_state         = state_q;
    assign mem.mem_req_valid = (state_q == REQ);
    assign mem.mem_req_we    = we_q;
    assign mem.mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
    // wstrb is gated so an idle/load bus shows all-zero byte enables
    assign mem.mem_req_wstrb = we_q ? lsu_wstrb(op_q, addr_q[1:0]) : 4'b0000;
    always_comb begin
        case (op_q[1:0])
            2'b00:   mem.mem_req_wdata = {(XLEN/8){wdata_q[7:0]}};
            2'b01:   mem.mem_req_wdata = {(XLEN/16){wdata_q[15:0]}};
            default: mem.mem_req_wdata = wdata_q;
        endcase
    end
endmodule

// File: tb/tb_ysyx_lsu.sv
// Self-checking bench for ysyx_lsu: memory model, directed load/store/flush/suppression
// cases, then a randomized mix; results checked through an expected-value scoreboard.
module tb_ysyx_lsu;
    import ysyx_lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clock, reset, flush_pipeline, exu_ren, exu_wen, exu_avalid;
    logic [4:0]  exu_alu_op;
    logic [31:0] exu_rwaddr, exu_wdata, lsu_rdata;
    logic        lsu_exu_rvalid, lsu_exu_wready, lsu_misalign;
    lsu_state_e  dbg_state;

    ysyx_lsu_if bus ();

    ysyx_lsu dut (
        .clock          (clock),
        .reset          (reset),
        .flush_pipeline (flush_pipeline),
        .exu_ren        (exu_ren),
        .exu_wen        (exu_wen),
        .exu_avalid     (exu_avalid),
        .exu_alu_op     (exu_alu_op),
        .exu_rwaddr     (exu_rwaddr),
        .exu_wdata      (exu_wdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_exu_rvalid (lsu_exu_rvalid),
        .lsu_exu_wready (lsu_exu_wready),
        .lsu_misalign   (lsu_misalign),
        .dbg_state      (dbg_state),
        .mem            (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    req_t        req_q[$];
    int          exp_wr = 0;
    int          n_req = 0;
    int          rsp_delay = 0;
    bit          rdy_rand = 0;
    bit          rdy_low = 0;
    bit          hs_seen = 0;
    logic [31:0] hs_addr;
    logic [31:0] mem_words [logic [31:0]];
    int          last_lat;

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] fmt_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] strb_model(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] s;
        s = 4'b0000;
        if (op[1:0] == 2'b00) s[a] = 1'b1;
        else if (op[1:0] == 2'b01) begin
            s[a] = 1'b1;
            s[a + 2'd1] = 1'b1;
        end else s = 4'b1111;
        return s;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] op, input logic [31:0] d);
        if (op[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (op[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // ---------------- memory model ----------------
    initial begin
        int          cnt;
        logic [31:0] pend;
        cnt = 0;
        pend = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.mem_rsp_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_rd(pend);
                end
            end
            if (hs_seen) begin
                hs_seen = 0;
                pend = hs_addr;
                cnt = rsp_delay;
                if (rsp_delay == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_rd(pend);
                end
            end
            bus.mem_req_ready = rdy_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        req_t r;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            n_req++;
            hs_seen = 1;
            hs_addr = bus.mem_req_addr;
            if (req_q.size() == 0) check("req_unexpected", 1, 0);
            else begin
                r = req_q.pop_front();
                check("req_addr", bus.mem_req_addr, r.addr);
                check("req_we", {31'h0, bus.mem_req_we}, {31'h0, r.we});
                if (r.we) begin
                    check("req_wdata", bus.mem_req_wdata, r.wdata);
                    check("req_wstrb", {28'h0, bus.mem_req_wstrb}, {28'h0, r.wstrb});
                end
            end
        end
        if (lsu_exu_rvalid) begin
            if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
            else check("rdata", lsu_rdata, exp_q.pop_front());
        end
        if (lsu_exu_wready) begin
            if (exp_wr == 0) check("wready_unexpected", 1, 0);
            else exp_wr--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws);
        req_t r;
        r.we = we;
        r.addr = {a[31:2], 2'b00};
        r.wdata = wd;
        r.wstrb = ws;
        req_q.push_back(r);
    endtask

    task automatic wait_rvalid();
        int c;
        bit got;
        c = 0;
        got = 0;
        while (!got && c < 60) begin
            @(negedge clock);
            c++;
            got = lsu_exu_rvalid;
        end
        last_lat = c;
        check("load_done", {31'h0, got}, 1);
    endtask

    task automatic wait_hs();
        int c;
        bit h;
        c = 0;
        h = 0;
        while (!h && c < 60) begin
            @(negedge clock);
            c++;
            h = bus.mem_req_valid && bus.mem_req_ready;
        end
        check("handshake", {31'h0, h}, 1);
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] expv);
        mem_words[{a[31:2], 2'b00}] = w;
        exp_q.push_back(expv);
        push_req(1'b0, a, 32'h0, 4'h0);
        exu_alu_op = {2'b00, op};
        exu_rwaddr = a;
        exu_ren = 1'b1;
        exu_avalid = 1'b1;
        wait_rvalid();
        @(posedge clock); #1;
        exu_ren = 1'b0;
        exu_avalid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic do_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_wd, input logic [3:0] exp_ws);
        int c;
        bit got;
        exp_wr++;
        push_req(1'b1, a, exp_wd, exp_ws);
        exu_alu_op = {2'b00, op};
        exu_rwaddr = a;
        exu_wdata = d;
        exu_wen = 1'b1;
        exu_avalid = 1'b1;
        @(posedge clock); #1;
        exu_wen = 1'b0;
        exu_avalid = 1'b0;
        c = 0;
        got = 0;
        while (!got && c < 60) begin
            @(negedge clock);
            c++;
            got = lsu_exu_wready;
        end
        check("store_done", {31'h0, got}, 1);
        @(posedge clock); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        reset = 1'b0;
        flush_pipeline = 1'b0;
        exu_ren = 1'b0;
        exu_wen = 1'b0;
        exu_avalid = 1'b0;
        exu_alu_op = '0;
        exu_rwaddr = '0;
        exu_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_state", dbg_state, IDLE);
        check("rst_req_valid", {31'h0, bus.mem_req_valid}, 0);
        check("rst_req_addr", bus.mem_req_addr, 0);
        check("rst_req_wstrb", {28'h0, bus.mem_req_wstrb}, 0);
        check("rst_rvalid", {31'h0, lsu_exu_rvalid}, 0);
        check("rst_wready", {31'h0, lsu_exu_wready}, 0);
        check("rst_rdata", lsu_rdata, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // basic loads, 1-cycle memory
        do_load(LSU_W, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("lw_latency", last_lat - 1, 3);
        do_load(LSU_B,  32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
        do_load(LSU_BU, 32'h1000_0003, 32'h80FF_1234, 32'h0000_0080);
        do_load(LSU_H,  32'h1000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
        do_load(LSU_HU, 32'h1000_0002, 32'h80FF_1234, 32'h0000_80FF);
        do_load(LSU_B,  32'h1000_0001, 32'h80FF_1234, 32'h0000_0012);
        do_load(LSU_H,  32'h1000_0000, 32'h80FF_9234, 32'hFFFF_9234);

        // stores
        do_store(LSU_H, 32'h2000_0002, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b1100);
        do_store(LSU_B, 32'h2000_0001, 32'h0000_0077, 32'h7777_7777, 4'b0010);
        do_store(LSU_W, 32'h2000_0008, 32'h1234_5678, 32'h1234_5678, 4'b1111);

        // flush while waiting for the response: the late response is drained
        rsp_delay = 2;
        mem_words[32'h3000_0000] = 32'h1111_2222;
        push_req(1'b0, 32'h3000_0000, 32'h0, 4'h0);
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h3000_0000; exu_ren = 1'b1; exu_avalid = 1'b1;
        wait_hs();
        @(posedge clock); #1;
        flush_pipeline = 1'b1; exu_ren = 1'b0; exu_avalid = 1'b0;
        @(posedge clock); #1;
        flush_pipeline = 1'b0;
        @(negedge clock);
        check("flush_rsp_drain", dbg_state, DRAIN);
        repeat (4) @(posedge clock); #1;
        check("drain_done_idle", dbg_state, IDLE);
        rsp_delay = 0;
        do_load(LSU_W, 32'h3000_0010, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // flush in the same cycle as the response
        push_req(1'b0, 32'h3000_0020, 32'h0, 4'h0);
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h3000_0020; exu_ren = 1'b1; exu_avalid = 1'b1;
        wait_hs();
        @(posedge clock); #1;
        flush_pipeline = 1'b1; exu_ren = 1'b0; exu_avalid = 1'b0;
        @(posedge clock); #1;
        flush_pipeline = 1'b0;
        @(negedge clock);
        check("flush_rsp_same_idle", dbg_state, IDLE);
        check("flush_rsp_same_rvalid", {31'h0, lsu_exu_rvalid}, 0);
        @(posedge clock); #1;

        // flush while the request is still unaccepted
        rdy_low = 1; bus.mem_req_ready = 1'b0;
        n0 = n_req;
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h3000_0030; exu_ren = 1'b1; exu_avalid = 1'b1;
        @(posedge clock); #1;
        check("req_state", dbg_state, REQ);
        check("req_valid_held", {31'h0, bus.mem_req_valid}, 1);
        flush_pipeline = 1'b1; exu_ren = 1'b0; exu_avalid = 1'b0;
        @(posedge clock); #1;
        flush_pipeline = 1'b0;
        @(negedge clock);
        check("flush_req_idle", dbg_state, IDLE);
        check("flush_req_no_valid", {31'h0, bus.mem_req_valid}, 0);
        rdy_low = 0;
        @(posedge clock); #1;
        check("flush_req_no_issue", n_req - n0, 0);

        // flush on an IDLE accept: load refused, store taken and still completes
        flush_pipeline = 1'b1; exu_ren = 1'b1; exu_avalid = 1'b1;
        @(posedge clock); #1;
        exu_ren = 1'b0; exu_avalid = 1'b0;
        @(negedge clock);
        check("flush_accept_load", dbg_state, IDLE);
        rsp_delay = 2;
        exp_wr++;
        push_req(1'b1, 32'h4000_0004, 32'h5566_7788, 4'b1111);
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h4000_0004; exu_wdata = 32'h5566_7788;
        @(posedge clock); #1;
        exu_wen = 1'b1; exu_avalid = 1'b1;
        @(posedge clock); #1;
        exu_wen = 1'b0; exu_avalid = 1'b0;
        @(negedge clock);
        check("flush_accept_store", dbg_state, REQ);
        repeat (3) @(posedge clock); #1;
        flush_pipeline = 1'b0;
        repeat (6) @(posedge clock); #1;
        check("store_flush_wready", exp_wr, 0);
        rsp_delay = 0;

        // suppression: held exu_ren re-issues only when the address changes
        n0 = n_req;
        mem_words[32'h5000_0000] = 32'hAAAA_0001;
        exp_q.push_back(32'hAAAA_0001);
        push_req(1'b0, 32'h5000_0000, 32'h0, 4'h0);
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h5000_0000; exu_ren = 1'b1; exu_avalid = 1'b1;
        wait_rvalid();
        repeat (4) @(posedge clock); #1;
        check("sup_one_req", n_req - n0, 1);
        mem_words[32'h5000_0004] = 32'hBBBB_0002;
        exp_q.push_back(32'hBBBB_0002);
        push_req(1'b0, 32'h5000_0004, 32'h0, 4'h0);
        exu_rwaddr = 32'h5000_0004;
        wait_rvalid();
        @(posedge clock); #1;
        check("sup_new_req", n_req - n0, 2);
        exu_ren = 1'b0; exu_avalid = 1'b0;
        @(posedge clock); #1;

        // misaligned word access
        n0 = n_req;
`ifdef YSYX_LSU_MISALIGN_EN
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h6000_0002; exu_ren = 1'b1; exu_avalid = 1'b1;
        @(posedge clock); #1;
        exu_ren = 1'b0; exu_avalid = 1'b0;
        @(negedge clock);
        check("misalign_pulse", {31'h0, lsu_misalign}, 1);
        check("misalign_idle", dbg_state, IDLE);
        check("misalign_no_valid", {31'h0, bus.mem_req_valid}, 0);
        @(negedge clock);
        check("misalign_one_cycle", {31'h0, lsu_misalign}, 0);
        @(posedge clock); #1;
        check("misalign_no_req", n_req - n0, 0);
`else
        do_load(LSU_W, 32'h6000_0002, 32'h0BAD_F00D, 32'h0BAD_F00D);
        check("misalign_tied_low", {31'h0, lsu_misalign}, 0);
        check("misalign_proceeds", n_req - n0, 1);
`endif

        // asynchronous reset in the middle of a request
        rdy_low = 1; bus.mem_req_ready = 1'b0;
        exu_alu_op = {2'b00, LSU_W}; exu_rwaddr = 32'h7000_0008; exu_ren = 1'b1; exu_avalid = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("pre_reset_valid", {31'h0, bus.mem_req_valid}, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, bus.mem_req_valid}, 0);
        check("async_rst_state", dbg_state, IDLE);
        check("async_rst_addr", bus.mem_req_addr, 0);
        check("async_rst_rdata", lsu_rdata, 0);
        exu_ren = 1'b0; exu_avalid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        rdy_low = 0;
        @(posedge clock); #1;

        // randomized mix with random ready and response delay
        rdy_rand = 1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, d;
            rsp_delay = $urandom_range(0, 2);
            a = {4'h9, 20'($urandom), 6'($urandom_range(0, 63)), 2'b00};
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 4))
                    0: op = LSU_B;
                    1: op = LSU_BU;
                    2: op = LSU_H;
                    3: op = LSU_HU;
                    default: op = LSU_W;
                endcase
                if (op[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
                else if (op[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
                do_load(op, a, d, fmt_model(op, a, d));
            end else begin
                op = 3'($urandom_range(0, 2));
                if (op == LSU_B) a[1:0] = 2'($urandom_range(0, 3));
                else if (op == LSU_H) a[1] = 1'($urandom_range(0, 1));
                do_store(op, a, d, wdata_model(op, d), strb_model(op, a[1:0]));
            end
        end
        rdy_rand = 0;
        repeat (4) @(posedge clock); #1;

        check("exp_q_drained", exp_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        check("wready_drained", exp_wr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
